// File: rtl/mmio_timer_pkg.sv
// Shared constants and CTRL layout for the memory-mapped interval timer.
package mmio_timer_pkg;

    localparam logic [1:0] TMR_COUNT   = 2'd0;
    localparam logic [1:0] TMR_COMPARE = 2'd1;
    localparam logic [1:0] TMR_CTRL    = 2'd2;
    localparam logic [1:0] TMR_STATUS  = 2'd3;

    localparam int TMR_EN_BIT     = 0;
    localparam int TMR_RELOAD_BIT = 1;
    localparam int TMR_IE_BIT     = 2;

    localparam logic [31:0] TMR_COMPARE_RST = 32'hFFFF_FFFF;

    typedef struct packed {
        logic ie;
        logic reload;
        logic en;
    } tmr_ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input tmr_ctrl_t c);
        logic [31:0] w;
        w                 = '0;
        w[TMR_EN_BIT]     = c.en;
        w[TMR_RELOAD_BIT] = c.reload;
        w[TMR_IE_BIT]     = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Count-tick prescaler: one tick every PRESCALE enabled cycles; clr restarts
// the period and swallows the tick of that cycle.
module tmr_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0]    LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = en & ~clr & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped interval timer with compare interrupt.
// Optional prescaler compiled in with `define MMIO_TIMER_PRESCALE_EN.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        timer_int
);

    logic [31:0] count;
    logic [31:0] compare;
    tmr_ctrl_t   ctrl;
    logic        pending;

    logic        wr_count, wr_compare, wr_ctrl, wr_status;
    logic        tick;
    logic [31:0] count_nxt;
    logic        match;

    assign wr_count   = sel & we & (addr == TMR_COUNT);
    assign wr_compare = sel & we & (addr == TMR_COMPARE);
    assign wr_ctrl    = sel & we & (addr == TMR_CTRL);
    assign wr_status  = sel & we & (addr == TMR_STATUS);

`ifdef MMIO_TIMER_PRESCALE_EN
    tmr_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.en),
        .clr   (wr_count),
        .tick  (tick)
    );
`else
    // Without a prescaler every enabled cycle ticks; a nonsensical PRESCALE of 0 disables it.
    localparam bit PRESCALE_OK = (PRESCALE >= 1);
    assign tick = ctrl.en & ~wr_count & PRESCALE_OK;
`endif

    // Wrap to 0 falls out of the 32-bit add, so COMPARE=0 matches on the wrap edge.
    assign count_nxt = (ctrl.reload && (count == compare)) ? 32'd0 : count + 32'd1;
    assign match     = tick & ~wr_compare & (count_nxt == compare);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            compare <= TMR_COMPARE_RST;
            ctrl    <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_count)
                count <= wdata;
            else if (tick)
                count <= count_nxt;

            if (wr_compare)
                compare <= wdata;

            if (wr_ctrl) begin
                ctrl.en     <= wdata[TMR_EN_BIT];
                ctrl.reload <= wdata[TMR_RELOAD_BIT];
                ctrl.ie     <= wdata[TMR_IE_BIT];
            end

            // A match beats a same-cycle STATUS clear.
            if (match)
                pending <= 1'b1;
            else if (wr_compare || (wr_status && wdata[0]))
                pending <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                TMR_COUNT:   rdata = count;
                TMR_COMPARE: rdata = compare;
                TMR_CTRL:    rdata = ctrl_to_word(ctrl);
                default:     rdata = {31'd0, pending};
            endcase
        end
    end

    assign timer_int = pending & ctrl.ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: reads push expectations, a monitor compares.
`timescale 1ns/1ps
module tb_mmio_timer;
    import mmio_timer_pkg::*;

`ifdef MMIO_TIMER_PRESCALE_EN
    localparam int T = 4;
`else
    localparam int T = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        timer_int;

    typedef struct packed {
        logic        is_int;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  smp = 1'b0;
    int    tests = 0;
    int    fails = 0;

    mmio_timer #(.PRESCALE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .timer_int (timer_int)
    );

    always #10 clk = ~clk;

    always @(posedge smp) begin
        exp_t        e;
        string       nm;
        logic [31:0] act;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: sample with no expectation queued");
        end else begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = e.is_int ? {31'd0, timer_int} : rdata;
            if (act !== e.val) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", nm, act, e.val);
            end
        end
    end

    task automatic push(input logic is_int, input logic [31:0] v, input string nm);
        exp_q.push_back('{is_int: is_int, val: v});
        name_q.push_back(nm);
        #1 smp = 1'b1;
        #1 smp = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        sel = 1'b1; we = 1'b0; addr = a;
        push(1'b0, e, nm);
        sel = 1'b0;
    endtask

    task automatic rd_int(input logic e, input string nm);
        push(1'b1, {31'd0, e}, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1 sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        edges(3);
        rst_n = 1'b1;
        rd(TMR_COUNT,   32'h0,        "rst_count");
        rd(TMR_COMPARE, 32'hFFFF_FFFF, "rst_compare");
        rd(TMR_CTRL,    32'h0,        "rst_ctrl");
        rd(TMR_STATUS,  32'h0,        "rst_status");
        rd_int(1'b0, "rst_int");
        addr = TMR_COMPARE;
        push(1'b0, 32'h0, "unsel_rdata");

        // Free run: COMPARE=3, pending exactly 3 ticks after the CTRL write
        wr(TMR_COMPARE, 32'd3);
        wr(TMR_CTRL, 32'b101);
        rd(TMR_CTRL, 32'b101, "ctrl_readback");
        edges(3*T - 1);
        rd(TMR_COUNT,  32'd2, "free_count_pre");
        rd(TMR_STATUS, 32'd0, "free_pend_pre");
        rd_int(1'b0, "free_int_pre");
        edges(1);
        rd(TMR_COUNT,  32'd3, "free_count_match");
        rd(TMR_STATUS, 32'd1, "free_pend_match");
        rd_int(1'b1, "free_int_match");
        edges(T);
        rd(TMR_COUNT, 32'd4, "free_count_after");
        wr(TMR_CTRL, 32'b000);
        wr(TMR_STATUS, 32'd1);
        rd(TMR_STATUS, 32'd0, "free_clear");

        // Auto-reload: 0,1,2,0,1,2
        wr(TMR_COUNT, 32'd0);
        wr(TMR_COMPARE, 32'd2);
        wr(TMR_CTRL, 32'b111);
        rd(TMR_COUNT,  32'd0, "rl_count0");
        rd(TMR_STATUS, 32'd0, "rl_pend0");
        for (int k = 1; k <= 5; k++) begin
            edges(T);
            rd(TMR_COUNT, 32'(k % 3), $sformatf("rl_count%0d", k));
            rd(TMR_STATUS, (k >= 2) ? 32'd1 : 32'd0, $sformatf("rl_pend%0d", k));
        end
        rd_int(1'b1, "rl_int_set");
        wr(TMR_STATUS, 32'd1);
        rd_int(1'b0, "rl_int_cleared");
        rd(TMR_STATUS, 32'd0, "rl_pend_cleared");
        wr(TMR_CTRL, 32'b000);

        // Wrap with COMPARE=0
        wr(TMR_COUNT, 32'hFFFF_FFFE);
        wr(TMR_COMPARE, 32'd0);
        wr(TMR_CTRL, 32'b101);
        edges(T);
        rd(TMR_COUNT,  32'hFFFF_FFFF, "wrap_count_max");
        rd(TMR_STATUS, 32'd0,         "wrap_pend_pre");
        edges(T);
        rd(TMR_COUNT,  32'd0, "wrap_count_zero");
        rd(TMR_STATUS, 32'd1, "wrap_pend_set");
        rd_int(1'b1, "wrap_int");
        wr(TMR_CTRL, 32'b000);
        wr(TMR_STATUS, 32'd1);

        // STATUS clear colliding with a match: set wins
        wr(TMR_COUNT, 32'd0);
        wr(TMR_COMPARE, 32'd2);
        wr(TMR_CTRL, 32'b101);
        edges(2*T - 1);
        wr(TMR_STATUS, 32'd1);
        rd(TMR_COUNT,  32'd2, "col_clr_count");
        rd(TMR_STATUS, 32'd1, "col_clr_pend");
        wr(TMR_CTRL, 32'b000);
        wr(TMR_STATUS, 32'd1);
        rd(TMR_STATUS, 32'd0, "col_clr_after");

        // COMPARE write colliding with a match: match suppressed
        wr(TMR_COUNT, 32'd0);
        wr(TMR_COMPARE, 32'd2);
        wr(TMR_CTRL, 32'b101);
        edges(2*T - 1);
        wr(TMR_COMPARE, 32'd2);
        rd(TMR_COUNT,  32'd2, "col_cmp_count");
        rd(TMR_STATUS, 32'd0, "col_cmp_pend");
        wr(TMR_CTRL, 32'b000);

        // COUNT write on a tick edge: written value wins
        wr(TMR_COUNT, 32'd0);
        wr(TMR_CTRL, 32'b001);
        edges(T - 1);
        wr(TMR_COUNT, 32'h100);
        rd(TMR_COUNT, 32'h100, "col_cnt_write");
        edges(T);
        rd(TMR_COUNT, 32'h101, "col_cnt_next");
        wr(TMR_CTRL, 32'b000);

        // Async reset between edges while pending
        wr(TMR_COUNT, 32'd0);
        wr(TMR_COMPARE, 32'd1);
        wr(TMR_CTRL, 32'b101);
        edges(T);
        rd_int(1'b1, "arst_int_pre");
        #1 rst_n = 1'b0;
        rd_int(1'b0, "arst_int");
        rd(TMR_COUNT,   32'd0,        "arst_count");
        rd(TMR_COMPARE, 32'hFFFF_FFFF, "arst_compare");
        rd(TMR_CTRL,    32'd0,        "arst_ctrl");
        @(posedge clk);
        #5 rst_n = 1'b1;
        edges(2);
        rd(TMR_COUNT,  32'd0, "arst_count_hold");
        rd(TMR_STATUS, 32'd0, "arst_status");

        #5;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
